// File: rtl/ex_stage_mem_reg_if.sv
// Execute-stage bus: ID/EX bundle and MEM/WB write-back in, EX/MEM register and branch resolution out.
// The master side drives the ID/EX bundle; the slave side is the execute stage.
interface ex_stage_mem_reg_if #(parameter int XLEN = 32);
    logic [XLEN-1:0] pc_ID_EX;
    logic [XLEN-1:0] data1_ID_EX;
    logic [XLEN-1:0] data2_ID_EX;
    logic [XLEN-1:0] immVal_ID_EX;
    logic [4:0]      rs1_ID_EX;
    logic [4:0]      rs2_ID_EX;
    logic [4:0]      rd_ID_EX;
    logic [3:0]      aluControl_ID_EX;
    logic            regWrite_ID_EX;
    logic            branch_ID_EX;
    logic            jump_ID_EX;
    logic            BEQ_ID_EX;
    logic            BNE_ID_EX;
    logic            memRead_ID_EX;
    logic            memWrite_ID_EX;
    logic            memToReg_ID_EX;
    logic            aluSrc_ID_EX;
    logic            wbRegWrite;
    logic [4:0]      wbRd;
    logic [XLEN-1:0] wbData;
    logic [XLEN-1:0] aluResult_EX_MEM;
    logic [XLEN-1:0] writeData_EX_MEM;
    logic [4:0]      rd_EX_MEM;
    logic            regWrite_EX_MEM;
    logic            memRead_EX_MEM;
    logic            memWrite_EX_MEM;
    logic            memToReg_EX_MEM;
    logic            pcSrc_EX;
    logic [XLEN-1:0] branchTarget_EX;
    logic            ex_busy;

    modport master (
        output pc_ID_EX, data1_ID_EX, data2_ID_EX, immVal_ID_EX,
        output rs1_ID_EX, rs2_ID_EX, rd_ID_EX, aluControl_ID_EX,
        output regWrite_ID_EX, branch_ID_EX, jump_ID_EX, BEQ_ID_EX, BNE_ID_EX,
        output memRead_ID_EX, memWrite_ID_EX, memToReg_ID_EX, aluSrc_ID_EX,
        output wbRegWrite, wbRd, wbData,
        input  aluResult_EX_MEM, writeData_EX_MEM, rd_EX_MEM,
        input  regWrite_EX_MEM, memRead_EX_MEM, memWrite_EX_MEM, memToReg_EX_MEM,
        input  pcSrc_EX, branchTarget_EX, ex_busy
    );

    modport slave (
        input  pc_ID_EX, data1_ID_EX, data2_ID_EX, immVal_ID_EX,
        input  rs1_ID_EX, rs2_ID_EX, rd_ID_EX, aluControl_ID_EX,
        input  regWrite_ID_EX, branch_ID_EX, jump_ID_EX, BEQ_ID_EX, BNE_ID_EX,
        input  memRead_ID_EX, memWrite_ID_EX, memToReg_ID_EX, aluSrc_ID_EX,
        input  wbRegWrite, wbRd, wbData,
        output aluResult_EX_MEM, writeData_EX_MEM, rd_EX_MEM,
        output regWrite_EX_MEM, memRead_EX_MEM, memWrite_EX_MEM, memToReg_EX_MEM,
        output pcSrc_EX, branchTarget_EX, ex_busy
    );
endinterface

// File: rtl/ex_stage_mem_reg.sv
// Execute stage with forwarding, ALU, branch resolution and the EX/MEM register.
// Latency: 1 cycle for single-cycle ops, 34 cycles for MUL (iterative shift-add).
// Backpressure: ex_busy holds IF/ID and ID/EX while a multiply is in flight; no other stall.
module ex_stage_mem_reg #(
    parameter int XLEN     = 32,
    parameter int MUL_ITER = 32
) (
    input  logic               clk,
    input  logic               reset,
    ex_stage_mem_reg_if.slave  bus
);
    localparam int CW = $clog2(MUL_ITER);
    localparam int SW = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(MUL_ITER - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    typedef struct packed {
        logic [XLEN-1:0] alu_result;
        logic [XLEN-1:0] write_data;
        logic [4:0]      rd;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
    } ex_mem_t;

    state_t          state_q, state_d;
    ex_mem_t         exm_q, exm_d, single_d;
    logic [XLEN-1:0] mcand_q, mplier_q, acc_q;
    logic [CW-1:0]   cnt_q;
    logic            mul_start, mul_step, busy;

    logic [XLEN-1:0] fwd_a, fwd_b, alu_b, alu_out, diff;
    logic            exm_fwd_ok, wb_fwd_ok, zero, taken, is_mul;

    // A load sitting in EX/MEM has no data yet, so it is never a forwarding source.
    assign exm_fwd_ok = exm_q.reg_write && !exm_q.mem_to_reg && (exm_q.rd != 5'd0);
    assign wb_fwd_ok  = bus.wbRegWrite && (bus.wbRd != 5'd0);

    assign fwd_a = (exm_fwd_ok && exm_q.rd == bus.rs1_ID_EX) ? exm_q.alu_result :
                   (wb_fwd_ok  && bus.wbRd == bus.rs1_ID_EX) ? bus.wbData : bus.data1_ID_EX;
    assign fwd_b = (exm_fwd_ok && exm_q.rd == bus.rs2_ID_EX) ? exm_q.alu_result :
                   (wb_fwd_ok  && bus.wbRd == bus.rs2_ID_EX) ? bus.wbData : bus.data2_ID_EX;
    assign alu_b = bus.aluSrc_ID_EX ? bus.immVal_ID_EX : fwd_b;

    assign diff   = fwd_a - fwd_b;
    assign zero   = (diff == '0);
    assign taken  = bus.jump_ID_EX
                  | (bus.branch_ID_EX & bus.BEQ_ID_EX & zero)
                  | (bus.branch_ID_EX & bus.BNE_ID_EX & ~zero);
    assign is_mul = (bus.aluControl_ID_EX == 4'd8);

    always_comb begin
        alu_out = '0;
        case (bus.aluControl_ID_EX)
            4'd0: alu_out = fwd_a + alu_b;
            4'd1: alu_out = fwd_a - alu_b;
            4'd2: alu_out = fwd_a & alu_b;
            4'd3: alu_out = fwd_a | alu_b;
            4'd4: alu_out = fwd_a ^ alu_b;
            4'd5: alu_out = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(alu_b))};
            4'd6: alu_out = fwd_a << alu_b[SW-1:0];
            4'd7: alu_out = fwd_a >> alu_b[SW-1:0];
            default: alu_out = '0;
        endcase
    end

    always_comb begin
        single_d            = '0;
        single_d.alu_result = bus.jump_ID_EX ? (bus.pc_ID_EX + XLEN'(4)) : alu_out;
        single_d.write_data = fwd_b;
        single_d.rd         = bus.rd_ID_EX;
        single_d.reg_write  = bus.regWrite_ID_EX & ~bus.branch_ID_EX;
        single_d.mem_read   = bus.memRead_ID_EX  & ~bus.branch_ID_EX;
        single_d.mem_write  = bus.memWrite_ID_EX & ~bus.branch_ID_EX;
        single_d.mem_to_reg = bus.memToReg_ID_EX;
    end

    always_comb begin
        state_d   = state_q;
        exm_d     = single_d;
        busy      = 1'b0;
        mul_start = 1'b0;
        mul_step  = 1'b0;
        case (state_q)
            IDLE: begin
                if (is_mul) begin
                    busy      = 1'b1;
                    mul_start = 1'b1;
                    exm_d     = '0;
                    state_d   = RUN;
                end
            end
            RUN: begin
                busy     = 1'b1;
                mul_step = 1'b1;
                exm_d    = '0;
                if (cnt_q == CNT_LAST) state_d = DONE;
            end
            DONE: begin
                // The ID/EX bundle was held throughout, so rd/regWrite still belong to the MUL.
                exm_d            = '0;
                exm_d.alu_result = acc_q;
                exm_d.rd         = bus.rd_ID_EX;
                exm_d.reg_write  = bus.regWrite_ID_EX;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            exm_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_d;
            exm_q   <= exm_d;
            if (mul_start) begin
                mcand_q  <= fwd_a;
                mplier_q <= alu_b;
                acc_q    <= '0;
                cnt_q    <= '0;
            end else if (mul_step) begin
                if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CW'(1);
            end
        end
    end

    assign bus.aluResult_EX_MEM = exm_q.alu_result;
    assign bus.writeData_EX_MEM = exm_q.write_data;
    assign bus.rd_EX_MEM        = exm_q.rd;
    assign bus.regWrite_EX_MEM  = exm_q.reg_write;
    assign bus.memRead_EX_MEM   = exm_q.mem_read;
    assign bus.memWrite_EX_MEM  = exm_q.mem_write;
    assign bus.memToReg_EX_MEM  = exm_q.mem_to_reg;
    assign bus.pcSrc_EX         = (state_q == IDLE) && !is_mul && taken;
    assign bus.branchTarget_EX  = bus.pc_ID_EX + bus.immVal_ID_EX;
    assign bus.ex_busy          = busy;
endmodule

// File: tb/tb_ex_stage_mem_reg.sv
// Randomized and directed bench for ex_stage_mem_reg; a scoreboard queue holds the expected EX/MEM contents.
// A monitor pops one entry after every clock edge at which the driver issued a cycle.
module tb_ex_stage_mem_reg;
    logic clk;
    logic reset;

    ex_stage_mem_reg_if #(.XLEN(32)) bus();

    ex_stage_mem_reg #(.XLEN(32), .MUL_ITER(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] wd;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        mtr;
    } exm_t;

    exm_t m;
    exm_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exm_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("aluResult_EX_MEM", bus.aluResult_EX_MEM, e.alu);
                chk("writeData_EX_MEM", bus.writeData_EX_MEM, e.wd);
                chk("rd_EX_MEM",        32'(bus.rd_EX_MEM),       32'(e.rd));
                chk("regWrite_EX_MEM",  32'(bus.regWrite_EX_MEM), 32'(e.rw));
                chk("memRead_EX_MEM",   32'(bus.memRead_EX_MEM),  32'(e.mr));
                chk("memWrite_EX_MEM",  32'(bus.memWrite_EX_MEM), 32'(e.mw));
                chk("memToReg_EX_MEM",  32'(bus.memToReg_EX_MEM), 32'(e.mtr));
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    function automatic logic [31:0] fwd(input logic [4:0] rs, input logic [31:0] reg_val);
        if (m.rw && !m.mtr && m.rd != 5'd0 && m.rd == rs) return m.alu;
        if (bus.wbRegWrite && bus.wbRd != 5'd0 && bus.wbRd == rs) return bus.wbData;
        return reg_val;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return a << b[4:0];
            4'd7: return a >> b[4:0];
            4'd8: return a * b;
            default: return 32'd0;
        endcase
    endfunction

    task automatic cycle(input logic busy, input logic pcs, input exm_t e);
        #1;
        chk("ex_busy",         32'(bus.ex_busy),  32'(busy));
        chk("pcSrc_EX",        32'(bus.pcSrc_EX), 32'(pcs));
        chk("branchTarget_EX", bus.branchTarget_EX, bus.pc_ID_EX + bus.immVal_ID_EX);
        q.push_back(e);
        @(posedge clk);
        m = e;
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        bus.pc_ID_EX = '0; bus.data1_ID_EX = '0; bus.data2_ID_EX = '0; bus.immVal_ID_EX = '0;
        bus.rs1_ID_EX = '0; bus.rs2_ID_EX = '0; bus.rd_ID_EX = '0; bus.aluControl_ID_EX = '0;
        bus.regWrite_ID_EX = 0; bus.branch_ID_EX = 0; bus.jump_ID_EX = 0; bus.BEQ_ID_EX = 0;
        bus.BNE_ID_EX = 0; bus.memRead_ID_EX = 0; bus.memWrite_ID_EX = 0; bus.memToReg_ID_EX = 0;
        bus.aluSrc_ID_EX = 0; bus.wbRegWrite = 0; bus.wbRd = '0; bus.wbData = '0;
    endtask

    task automatic single();
        logic [31:0] fa, fb, b;
        logic        z, pcs;
        exm_t        e;
        fa  = fwd(bus.rs1_ID_EX, bus.data1_ID_EX);
        fb  = fwd(bus.rs2_ID_EX, bus.data2_ID_EX);
        b   = bus.aluSrc_ID_EX ? bus.immVal_ID_EX : fb;
        z   = (fa == fb);
        pcs = bus.jump_ID_EX || (bus.branch_ID_EX && bus.BEQ_ID_EX && z)
                             || (bus.branch_ID_EX && bus.BNE_ID_EX && !z);
        e.alu = bus.jump_ID_EX ? bus.pc_ID_EX + 32'd4 : ref_alu(bus.aluControl_ID_EX, fa, b);
        e.wd  = fb;
        e.rd  = bus.rd_ID_EX;
        e.rw  = bus.regWrite_ID_EX && !bus.branch_ID_EX;
        e.mr  = bus.memRead_ID_EX  && !bus.branch_ID_EX;
        e.mw  = bus.memWrite_ID_EX && !bus.branch_ID_EX;
        e.mtr = bus.memToReg_ID_EX;
        cycle(1'b0, pcs, e);
    endtask

    task automatic rst_chk(input string tag);
        chk({tag, "_aluResult"}, bus.aluResult_EX_MEM, 32'd0);
        chk({tag, "_writeData"}, bus.writeData_EX_MEM, 32'd0);
        chk({tag, "_rd"},        32'(bus.rd_EX_MEM), 32'd0);
        chk({tag, "_ctrl"},      32'({bus.regWrite_EX_MEM, bus.memRead_EX_MEM,
                                      bus.memWrite_EX_MEM, bus.memToReg_EX_MEM}), 32'd0);
        chk({tag, "_ex_busy"},   32'(bus.ex_busy), 32'd0);
    endtask

    function automatic logic [31:0] rnd_val();
        return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : 32'($urandom);
    endfunction

    // Multiply: one IDLE-latch cycle plus 32 RUN cycles busy, then the DONE write-back.
    task automatic mul(input int abort_at);
        logic [31:0] fa, fb, prod, s_pc, s_d1, s_d2, s_imm;
        exm_t        e;
        fa   = fwd(bus.rs1_ID_EX, bus.data1_ID_EX);
        fb   = fwd(bus.rs2_ID_EX, bus.data2_ID_EX);
        prod = fa * (bus.aluSrc_ID_EX ? bus.immVal_ID_EX : fb);
        s_pc = bus.pc_ID_EX; s_d1 = bus.data1_ID_EX; s_d2 = bus.data2_ID_EX; s_imm = bus.immVal_ID_EX;
        cycle(1'b1, 1'b0, '0);
        for (int i = 0; i < 32; i++) begin
            if (i == abort_at) begin
                bus.aluControl_ID_EX = 4'd0;
                reset = 1'b0;
                #1;
                rst_chk("mid_mul_rst");
                @(posedge clk);
                #1;
                rst_chk("mid_mul_hold");
                @(negedge clk);
                reset = 1'b1;
                m = '0;
                clear_inputs();
                bus.data1_ID_EX = 32'd3; bus.immVal_ID_EX = 32'd4; bus.aluSrc_ID_EX = 1;
                bus.rd_ID_EX = 5'd1; bus.regWrite_ID_EX = 1;
                single();
                chk("post_reset_add", bus.aluResult_EX_MEM, 32'd7);
                return;
            end
            // Operands are frozen at the latch, so the bus may wander during RUN.
            bus.pc_ID_EX = $urandom; bus.data1_ID_EX = $urandom; bus.data2_ID_EX = $urandom;
            bus.immVal_ID_EX = $urandom; bus.wbData = $urandom;
            cycle(1'b1, 1'b0, '0);
        end
        bus.pc_ID_EX = s_pc; bus.data1_ID_EX = s_d1; bus.data2_ID_EX = s_d2; bus.immVal_ID_EX = s_imm;
        e     = '0;
        e.alu = prod;
        e.rd  = bus.rd_ID_EX;
        e.rw  = bus.regWrite_ID_EX;
        cycle(1'b0, 1'b0, e);
    endtask

    task automatic rand_instr();
        int kind;
        bus.pc_ID_EX     = $urandom & 32'hFFFF_FFFC;
        bus.data1_ID_EX  = rnd_val();
        bus.data2_ID_EX  = rnd_val();
        bus.immVal_ID_EX = rnd_val();
        bus.rs1_ID_EX    = 5'($urandom_range(0, 7));
        bus.rs2_ID_EX    = 5'($urandom_range(0, 7));
        bus.rd_ID_EX     = 5'($urandom_range(0, 7));
        bus.aluSrc_ID_EX = 1'($urandom_range(0, 1));
        bus.regWrite_ID_EX = 1'($urandom_range(0, 1));
        bus.memRead_ID_EX  = ($urandom_range(0, 5) == 0);
        bus.memWrite_ID_EX = ($urandom_range(0, 5) == 0);
        bus.memToReg_ID_EX = ($urandom_range(0, 4) == 0);
        bus.wbRegWrite   = 1'($urandom_range(0, 1));
        bus.wbRd         = 5'($urandom_range(0, 7));
        bus.wbData       = rnd_val();
        bus.branch_ID_EX = 0; bus.jump_ID_EX = 0; bus.BEQ_ID_EX = 0; bus.BNE_ID_EX = 0;
        if ($urandom_range(0, 99) < 12) begin
            bus.aluControl_ID_EX = 4'd8;
            bus.memRead_ID_EX = 0; bus.memWrite_ID_EX = 0; bus.memToReg_ID_EX = 0;
            mul(-1);
        end else begin
            bus.aluControl_ID_EX = 4'($urandom_range(0, 15));
            if (bus.aluControl_ID_EX == 4'd8) bus.aluControl_ID_EX = 4'd0;
            kind = $urandom_range(0, 9);
            if (kind == 0) begin
                bus.branch_ID_EX = 1;
                bus.BEQ_ID_EX = 1'($urandom_range(0, 1));
                bus.BNE_ID_EX = !bus.BEQ_ID_EX;
            end else if (kind == 1) begin
                bus.jump_ID_EX = 1;
            end
            single();
        end
    endtask

    initial begin : driver
        clear_inputs();
        m = '0;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        rst_chk("reset");
        reset = 1'b1;

        // ADD chain: WB forward, then EX/MEM forward beating a WB hit on the same register.
        bus.wbRegWrite = 1; bus.wbRd = 5'd1; bus.wbData = 32'd5;
        bus.rd_ID_EX = 5'd2; bus.rs1_ID_EX = 5'd1; bus.immVal_ID_EX = 32'd7;
        bus.aluSrc_ID_EX = 1; bus.regWrite_ID_EX = 1;
        single();
        chk("add_wb_fwd", bus.aluResult_EX_MEM, 32'd12);
        bus.wbRd = 5'd2; bus.wbData = 32'd100;
        bus.rd_ID_EX = 5'd3; bus.rs1_ID_EX = 5'd2; bus.rs2_ID_EX = 5'd2; bus.aluSrc_ID_EX = 0;
        single();
        chk("add_exmem_fwd", bus.aluResult_EX_MEM, 32'd24);

        // Branches with unforwarded operands.
        clear_inputs();
        bus.data1_ID_EX = 32'd9; bus.data2_ID_EX = 32'd9; bus.branch_ID_EX = 1; bus.BEQ_ID_EX = 1;
        bus.pc_ID_EX = 32'h40; bus.immVal_ID_EX = 32'h10; bus.regWrite_ID_EX = 1; bus.rd_ID_EX = 5'd4;
        #1;
        chk("beq_taken", 32'(bus.pcSrc_EX), 32'd1);
        chk("beq_target", bus.branchTarget_EX, 32'h50);
        single();
        chk("beq_no_regwrite", 32'(bus.regWrite_EX_MEM), 32'd0);
        bus.data2_ID_EX = 32'd8; bus.BEQ_ID_EX = 0; bus.BNE_ID_EX = 1;
        #1;
        chk("bne_taken", 32'(bus.pcSrc_EX), 32'd1);
        single();
        bus.BEQ_ID_EX = 1; bus.BNE_ID_EX = 0;
        #1;
        chk("beq_not_taken", 32'(bus.pcSrc_EX), 32'd0);
        single();

        // Jump.
        clear_inputs();
        bus.jump_ID_EX = 1; bus.pc_ID_EX = 32'h100; bus.immVal_ID_EX = 32'hFFFF_FFF8;
        bus.rd_ID_EX = 5'd1; bus.regWrite_ID_EX = 1;
        #1;
        chk("jump_pcsrc", 32'(bus.pcSrc_EX), 32'd1);
        chk("jump_target", bus.branchTarget_EX, 32'hF8);
        single();
        chk("jump_link", bus.aluResult_EX_MEM, 32'h104);

        // Multiplies.
        clear_inputs();
        bus.aluControl_ID_EX = 4'd8; bus.data1_ID_EX = 32'hFFFF_FFFF; bus.data2_ID_EX = 32'd3;
        bus.rd_ID_EX = 5'd5; bus.regWrite_ID_EX = 1;
        mul(-1);
        chk("mul_neg1x3", bus.aluResult_EX_MEM, 32'hFFFF_FFFD);
        chk("mul_rd", 32'(bus.rd_EX_MEM), 32'd5);
        bus.data1_ID_EX = 32'd7; bus.data2_ID_EX = 32'd6; bus.rd_ID_EX = 5'd6;
        mul(-1);
        chk("mul_7x6", bus.aluResult_EX_MEM, 32'd42);

        // SLT / SRL / SLL / undefined op.
        clear_inputs();
        bus.aluSrc_ID_EX = 1; bus.regWrite_ID_EX = 1; bus.rd_ID_EX = 5'd7;
        bus.aluControl_ID_EX = 4'd5; bus.data1_ID_EX = 32'hFFFF_FFFF; bus.immVal_ID_EX = 32'd1;
        single();
        chk("slt_signed", bus.aluResult_EX_MEM, 32'd1);
        bus.aluControl_ID_EX = 4'd7; bus.data1_ID_EX = 32'h8000_0000; bus.immVal_ID_EX = 32'd31;
        single();
        chk("srl_31", bus.aluResult_EX_MEM, 32'd1);
        bus.aluControl_ID_EX = 4'd6; bus.data1_ID_EX = 32'd1;
        single();
        chk("sll_31", bus.aluResult_EX_MEM, 32'h8000_0000);
        bus.aluControl_ID_EX = 4'd12; bus.data1_ID_EX = 32'h1234_5678;
        single();
        chk("op12_zero", bus.aluResult_EX_MEM, 32'd0);

        // Reset during RUN cycle 10.
        clear_inputs();
        bus.aluControl_ID_EX = 4'd8; bus.data1_ID_EX = 32'd11; bus.data2_ID_EX = 32'd13;
        bus.rd_ID_EX = 5'd3; bus.regWrite_ID_EX = 1;
        mul(10);

        for (int n = 0; n < 200; n++) rand_instr();

        @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
